// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result FIFO behind the 64-bit ALU, with per-entry status flags,
// a sticky zero flag and a saturating pop counter. Define ALU_RES_PARITY_EN to add res_parity.
module alu_result_stage #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [WIDTH-1:0] in_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_opcode,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_neg,
  output logic             res_cmp,
  input  logic             sticky_clr,
  output logic             sticky_zero,
`ifdef ALU_RES_PARITY_EN
  output logic             res_parity,
`endif
  output logic [CNT_W-1:0] op_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [3:0]       opcode;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             neg;
    logic             cmp;
`ifdef ALU_RES_PARITY_EN
    logic             parity;
`endif
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            head_q, head_d, new_entry;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              valid_q;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;
  logic              push, pop;

  // Handshakes: a transfer happens on a rising edge where valid && ready. in_ready depends
  // only on the registered fill level; res_valid holds with stable head fields until popped.
  assign in_ready = (count_q != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = valid_q && res_ready;

  always_comb begin
    new_entry        = '0;
    new_entry.opcode = in_opcode;
    new_entry.data   = in_result;
    new_entry.zero   = (in_result == '0);
    new_entry.neg    = in_result[WIDTH-1];
    new_entry.cmp    = ((in_opcode == 4'd6) || (in_opcode == 4'd9) || (in_opcode == 4'd11))
                       && in_result[0];
`ifdef ALU_RES_PARITY_EN
    new_entry.parity = ^in_result;
`endif
  end

  // Head register is reloaded whenever the entry at the read pointer changes; it holds when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    head_d   = head_q;
    if (count_d != '0) begin
      if ((count_q == '0) || (pop && (count_q == (PW+1)'(1)))) head_d = new_entry;
      else                                                      head_d = mem_q[rd_ptr_d];
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    if (pop && head_q.zero) sticky_d = 1'b1;
    else if (sticky_clr)    sticky_d = 1'b0;
    op_count_d = op_count_q;
    if (pop && (op_count_q != '1)) op_count_d = op_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      sticky_q   <= 1'b0;
      op_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= (count_d != '0);
      head_q     <= head_d;
      sticky_q   <= sticky_d;
      op_count_q <= op_count_d;
    end
  end

  assign res_valid   = valid_q;
  assign res_opcode  = head_q.opcode;
  assign res_data    = head_q.data;
  assign res_zero    = head_q.zero;
  assign res_neg     = head_q.neg;
  assign res_cmp     = head_q.cmp;
  assign sticky_zero = sticky_q;
  assign op_count    = op_count_q;
`ifdef ALU_RES_PARITY_EN
  assign res_parity  = head_q.parity;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed vectors with literal checks plus a queue-based reference
// model compared against every output on each falling clock edge.
module tb_alu_result_stage;
  localparam int W  = 64;
  localparam int D  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_opcode = '0;
  logic [W-1:0]  in_result = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [3:0]    res_opcode;
  logic [W-1:0]  res_data;
  logic          res_zero, res_neg, res_cmp;
  logic          sticky_clr = 1'b0;
  logic          sticky_zero;
  logic [CW-1:0] op_count;
`ifdef ALU_RES_PARITY_EN
  logic          res_parity;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_result  (in_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_opcode (res_opcode),
    .res_data   (res_data),
    .res_zero   (res_zero),
    .res_neg    (res_neg),
    .res_cmp    (res_cmp),
    .sticky_clr (sticky_clr),
    .sticky_zero(sticky_zero),
`ifdef ALU_RES_PARITY_EN
    .res_parity (res_parity),
`endif
    .op_count   (op_count)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] data;
    logic         z;
    logic         n;
    logic         c;
    logic         p;
  } ent_t;

  ent_t          exp_q[$];
  ent_t          m_last;
  logic          m_sticky;
  logic [CW-1:0] m_cnt;
  logic          m_push;

  function automatic ent_t mk(input logic [3:0] op, input logic [W-1:0] d);
    ent_t e;
    e.op   = op;
    e.data = d;
    e.z    = (d == '0);
    e.n    = d[W-1];
    e.c    = (op == 4'd6 || op == 4'd9 || op == 4'd11) ? d[0] : 1'b0;
    e.p    = ^d;
    return e;
  endfunction

  initial begin
    m_last = '0; m_sticky = 1'b0; m_cnt = '0; m_push = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        m_last = '0; m_sticky = 1'b0; m_cnt = '0;
      end else begin
        m_push = in_valid && (exp_q.size() < D);
        if (res_ready && exp_q.size() > 0) begin
          m_last = exp_q.pop_front();
          if (m_last.z)        m_sticky = 1'b1;
          else if (sticky_clr) m_sticky = 1'b0;
          if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end else if (sticky_clr) begin
          m_sticky = 1'b0;
        end
        if (m_push) exp_q.push_back(mk(in_opcode, in_result));
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    ent_t h;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        h = (exp_q.size() > 0) ? exp_q[0] : m_last;
        chk("m_in_ready",  W'(in_ready),    W'(exp_q.size() < D));
        chk("m_res_valid", W'(res_valid),   W'(exp_q.size() > 0));
        chk("m_opcode",    W'(res_opcode),  W'(h.op));
        chk("m_data",      res_data,        h.data);
        chk("m_zero",      W'(res_zero),    W'(h.z));
        chk("m_neg",       W'(res_neg),     W'(h.n));
        chk("m_cmp",       W'(res_cmp),     W'(h.c));
        chk("m_sticky",    W'(sticky_zero), W'(m_sticky));
        chk("m_op_count",  W'(op_count),    W'(m_cnt));
`ifdef ALU_RES_PARITY_EN
        chk("m_parity",    W'(res_parity),  W'(h.p));
`endif
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [3:0] op, input logic [W-1:0] d,
                      input logic rr, input logic clr);
    in_valid = v; in_opcode = op; in_result = d; res_ready = rr; sticky_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready",  W'(in_ready),    W'(1));
    chk("rst_res_valid", W'(res_valid),   W'(0));
    chk("rst_op_count",  W'(op_count),    W'(0));
    chk("rst_sticky",    W'(sticky_zero), W'(0));
    chk("rst_res_data",  res_data,        '0);

    // single zero result
    step(1'b1, 4'd5, '0, 1'b1, 1'b0);
    chk("zero_valid", W'(res_valid), W'(1));
    chk("zero_flag",  W'(res_zero),  W'(1));
    chk("zero_neg",   W'(res_neg),   W'(0));
    chk("zero_op",    W'(res_opcode), W'(5));
    step(1'b0, 4'd0, '0, 1'b1, 1'b0);
    chk("zero_popped", W'(res_valid),   W'(0));
    chk("zero_sticky", W'(sticky_zero), W'(1));
    chk("zero_count",  W'(op_count),    W'(1));

    // fill to full with consumer stalled
    step(1'b1, 4'd0, 64'h8000_0000_0000_0001, 1'b0, 1'b0);
    chk("fill_neg",   W'(res_neg),  W'(1));
    chk("fill_ready1", W'(in_ready), W'(1));
    step(1'b1, 4'd0, 64'h5, 1'b0, 1'b0);
    chk("full_ready", W'(in_ready), W'(0));
    step(1'b1, 4'd0, 64'h7, 1'b0, 1'b0);
    chk("full_hold_ready", W'(in_ready), W'(0));
    chk("full_hold_data",  res_data, 64'h8000_0000_0000_0001);
    step(1'b1, 4'd0, 64'h7, 1'b1, 1'b0);
    chk("pop1_data",  res_data, 64'h5);
    chk("pop1_ready", W'(in_ready), W'(1));
    step(1'b1, 4'd0, 64'h7, 1'b1, 1'b0);
    chk("pop2_data", res_data, 64'h7);
    step(1'b0, 4'd0, '0, 1'b1, 1'b0);
    chk("drain_count", W'(op_count), W'(4));

    // compare opcodes
    step(1'b1, 4'd11, 64'h1, 1'b1, 1'b0);
    chk("slt_cmp", W'(res_cmp), W'(1));
    step(1'b1, 4'd2, 64'h1, 1'b1, 1'b0);
    chk("op2_cmp", W'(res_cmp), W'(0));
    step(1'b0, 4'd0, '0, 1'b1, 1'b0);

    // sticky clear vs set
    step(1'b0, 4'd0, '0, 1'b0, 1'b1);
    chk("clr_alone0", W'(sticky_zero), W'(0));
    step(1'b1, 4'd9, '0, 1'b0, 1'b0);
    step(1'b0, 4'd0, '0, 1'b1, 1'b1);
    chk("set_wins", W'(sticky_zero), W'(1));
    step(1'b0, 4'd0, '0, 1'b0, 1'b1);
    chk("clr_alone1", W'(sticky_zero), W'(0));

    // opcode 15 stored as-is, opcode 9 compare
    step(1'b1, 4'd15, 64'h1, 1'b0, 1'b0);
    chk("op15_cmp", W'(res_cmp),    W'(0));
    chk("op15_op",  W'(res_opcode), W'(15));
    step(1'b1, 4'd9, 64'h1, 1'b0, 1'b0);
    step(1'b0, 4'd0, '0, 1'b1, 1'b0);
    chk("sne_cmp", W'(res_cmp), W'(1));
    step(1'b0, 4'd0, '0, 1'b1, 1'b0);

    // reset with two entries held
    step(1'b1, 4'd4, 64'h3, 1'b0, 1'b0);
    step(1'b1, 4'd4, 64'h7, 1'b0, 1'b0);
    chk("held_data", res_data, 64'h3);
`ifdef ALU_RES_PARITY_EN
    chk("par3", W'(res_parity), W'(0));
`endif
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", W'(res_valid), W'(0));
    chk("mrst_ready", W'(in_ready),  W'(1));
    chk("mrst_count", W'(op_count),  W'(0));
    step(1'b0, 4'd0, '0, 1'b0, 1'b0);
    step(1'b0, 4'd0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 4'd0, '0, 1'b1, 1'b0);
    chk("post_rst_valid", W'(res_valid), W'(0));
    step(1'b1, 4'd4, 64'h7, 1'b0, 1'b0);
    chk("post_rst_data", res_data, 64'h7);
`ifdef ALU_RES_PARITY_EN
    chk("par7", W'(res_parity), W'(1));
`endif
    step(1'b0, 4'd0, '0, 1'b1, 1'b0);

    // throttled traffic, checked by the model
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom(), $urandom()},
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    repeat (3) step(1'b0, 4'd0, '0, 1'b1, 1'b0);

    // counter saturation
    for (int i = 0; i < 20; i++) step(1'b1, 4'd1, W'(i), 1'b1, 1'b0);
    repeat (2) step(1'b0, 4'd0, '0, 1'b1, 1'b0);
    chk("sat_count", W'(op_count), W'(4'hF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered downstream stage for the combinational 64-bit ALU.
- Captures ALU `result` plus its `opcode` under valid/ready handshake into a 2-entry FIFO.
- Derives registered status flags per entry; presents them to the writeback consumer.
- Keeps a sticky zero flag and a completed-operation counter for debug/perf.

Parameters:
- WIDTH, 64, data width of ALU result; must match ALU width.
- DEPTH, 2, FIFO entries; fixed power of two (2 or 4 supported).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU output valid this cycle.
- in_ready  output  1  stage can accept; equals !full, registered-only (no path from res_ready).
- in_opcode  input  4  opcode presented to ALU.
- in_result  input  WIDTH  ALU `result`.
- res_valid  output  1  head entry valid.
- res_ready  input  1  consumer accepts head entry.
- res_opcode  output  4  head entry opcode.
- res_data  output  WIDTH  head entry result.
- res_zero  output  1  head result == 0.
- res_neg  output  1  head result bit [WIDTH-1].
- res_cmp  output  1  for opcodes 6 (SEQ), 9 (SNE), 11 (SLT): head result bit 0; else 0.
- sticky_clr  input  1  synchronous clear of sticky_zero.
- sticky_zero  output  1  set when any popped entry had res_zero=1.
- op_count  output  CNT_W  number of popped entries, saturating.

Behaviour:
- Reset (async, rst_n=0): FIFO empty; rd/wr pointers, count = 0; res_valid=0, in_ready=1, res_data=0, res_opcode=0, res_zero/res_neg/res_cmp=0, sticky_zero=0, op_count=0. Reset mid-transfer drops all in-flight entries; no partial output after release.
- Push: in_valid && in_ready at edge N → entry written; res_valid=1 from cycle N+1 if FIFO was empty (1-cycle latency).
- Pop: res_valid && res_ready at edge → head retired; next entry (if any) visible next cycle.
- Flags computed at push time, stored with entry; res_* outputs are registered head fields, no combinational ALU-to-output path.
- Push and pop same cycle: count unchanged. Allowed when full only if in_ready already 1; since in_ready = !full, a full FIFO never accepts, even with simultaneous pop.
- Empty: res_valid=0; res_data/flags hold last popped values (don't-care for consumer, but must not be X).
- Pointer wrap: mod DEPTH; count range 0..DEPTH.
- in_valid while in_ready=0: ignored; upstream must hold.
- res_valid, once high, stays high with stable data until popped.
- sticky_zero: on pop of entry with res_zero=1, set. sticky_clr and such pop in the same cycle → sticky_zero=1 (set wins). sticky_clr alone → 0 next cycle.
- op_count: +1 per pop; saturates at all-ones, no wrap.
- Opcodes 12-15: stored as-is, res_cmp=0.

Optional Feature:
- Macro ALU_RES_PARITY_EN.
- Defined: adds output res_parity (1 bit) = even parity (XOR-reduce) of res_data, computed at push and stored per entry. Reset value 0.
- Undefined: no res_parity port, no parity storage.

Test Plan:
- Reset then idle → in_ready=1, res_valid=0, op_count=0, sticky_zero=0.
- Push opcode 5, result 64'h0 at cycle 1, res_ready=1 → res_valid at cycle 2 with res_zero=1, res_neg=0; after pop, sticky_zero=1, op_count=1.
- Push 3 back-to-back with res_ready=0 (results 64'h8000_0000_0000_0001, 64'h5, 64'h7) → first two accepted, in_ready=0 on third; res_neg=1 on head. Raise res_ready → pops in order 8000..01, 5; then 7 accepted and popped.
- Opcode 11 result 64'h1, then opcode 2 result 64'h1 → res_cmp=1 then 0.
- sticky_clr asserted in same cycle as pop of zero result → sticky_zero=1; next cycle sticky_clr alone → 0.
- Assert rst_n=0 mid-stream with 2 entries held → res_valid=0 immediately, FIFO empty after release; with ALU_RES_PARITY_EN, result 64'h3 → res_parity=0, 64'h7 → 1.
